// File: rtl/regfile_sb.sv
// Parametrised register file with zero register, busy scoreboard and synchronous clear.
// Define REGFILE_SB_FWD_EN to forward same-cycle writeback data and release busy to read ports.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         claim_en,
  input  logic [AW-1:0]                claim_addr,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy
);

  logic [DATA_WIDTH-1:0] data_reg [NUM_REGS];
  logic                  busy_reg [NUM_REGS];

  // Entry 0 is cleared by reset and never written; reads of address 0 are masked anyway.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) begin
        data_reg[r] <= '0;
        busy_reg[r] <= 1'b0;
      end else if (r != 0) begin
        if (wr_en && (wr_addr == AW'(r))) begin
          data_reg[r] <= wr_data;
        end
        // A claim outranks a release: the write belongs to the older producer.
        if (claim_en && (claim_addr == AW'(r))) begin
          busy_reg[r] <= 1'b1;
        end else if (wr_en && (wr_addr == AW'(r))) begin
          busy_reg[r] <= 1'b0;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          fwd_hit;
      logic          addr_zero;

      assign addr      = rd_addr[gi*AW +: AW];
      assign addr_zero = (addr == '0);
`ifdef REGFILE_SB_FWD_EN
      assign fwd_hit   = wr_en && (wr_addr != '0) && (wr_addr == addr);
`else
      assign fwd_hit   = 1'b0;
`endif

      always_comb begin
        rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_busy[gi]                          = 1'b0;
        if (!addr_zero) begin
          if (fwd_hit) begin
            rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = wr_data;
          end else begin
            rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg[addr];
            rd_busy[gi]                          = busy_reg[addr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32/2-port instance plus a 64-bit/16-reg/3-port instance.
// Expected values follow REGFILE_SB_FWD_EN when the bench is built with that macro.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef REGFILE_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Instance A: default parameters
  logic        wr_en_a, claim_en_a;
  logic [4:0]  wr_addr_a, claim_addr_a;
  logic [31:0] wr_data_a;
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;

  regfile_sb dut_a (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en_a),
    .wr_addr    (wr_addr_a),
    .wr_data    (wr_data_a),
    .claim_en   (claim_en_a),
    .claim_addr (claim_addr_a),
    .rd_addr    (rd_addr_a),
    .rd_data    (rd_data_a),
    .rd_busy    (rd_busy_a)
  );

  // Instance B: 64-bit, 16 registers, 3 read ports
  logic         wr_en_b, claim_en_b;
  logic [3:0]   wr_addr_b, claim_addr_b;
  logic [63:0]  wr_data_b;
  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_busy_b;

  regfile_sb #(.DATA_WIDTH(64), .NUM_REGS(16), .NUM_RD(3)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en_b),
    .wr_addr    (wr_addr_b),
    .wr_data    (wr_data_b),
    .claim_en   (claim_en_b),
    .claim_addr (claim_addr_b),
    .rd_addr    (rd_addr_b),
    .rd_data    (rd_data_b),
    .rd_busy    (rd_busy_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  // Advance one edge, then settle inputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_en_a = 1'b0; claim_en_a = 1'b0;
    wr_addr_a = '0; claim_addr_a = '0; wr_data_a = '0;
  endtask

  task automatic read_a(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr_a = {a1, a0};
    #1;
  endtask

  initial begin
    idle_a();
    rd_addr_a = '0;
    wr_en_b = 1'b0; claim_en_b = 1'b0; wr_addr_b = '0; claim_addr_b = '0;
    wr_data_b = '0; rd_addr_b = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Reset state
    read_a(5'd5, 5'd31);
    check_eq("rst_data0", rd_data_a[31:0], 64'h0);
    check_eq("rst_data1", rd_data_a[63:32], 64'h0);
    check_eq("rst_busy", rd_busy_a, 64'h0);

    // Fill every register with DEADBEEF while claiming it (claim wins -> busy)
    for (int i = 0; i < 32; i++) begin
      wr_en_a = 1'b1; wr_addr_a = 5'(i); wr_data_a = 32'hDEADBEEF;
      claim_en_a = 1'b1; claim_addr_a = 5'(i);
      step();
    end
    idle_a();
    read_a(5'd3, 5'd0);
    check_eq("fill_data3", rd_data_a[31:0], 64'hDEADBEEF);
    check_eq("fill_busy3", rd_busy_a[0], 64'h1);
    check_eq("fill_data0", rd_data_a[63:32], 64'h0);
    check_eq("fill_busy0", rd_busy_a[1], 64'h0);

    // Reset with pending write and claim: both ignored
    rst = 1'b1;
    wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'h5555AAAA;
    claim_en_a = 1'b1; claim_addr_a = 5'd6;
    step();
    rst = 1'b0;
    idle_a();
    for (int a = 1; a < 32; a++) begin
      read_a(5'(a), 5'(32 - a));
      check_eq($sformatf("clr_d0_r%0d", a), rd_data_a[31:0], 64'h0);
      check_eq($sformatf("clr_d1_r%0d", 32 - a), rd_data_a[63:32], 64'h0);
      check_eq($sformatf("clr_busy_r%0d", a), rd_busy_a, 64'h0);
    end

    // x0 protection across several cycles
    for (int c = 0; c < 3; c++) begin
      wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFFFFFF;
      claim_en_a = 1'b1; claim_addr_a = 5'd0;
      read_a(5'd0, 5'd0);
      check_eq($sformatf("x0_data_c%0d", c), rd_data_a, 64'h0);
      check_eq($sformatf("x0_busy_c%0d", c), rd_busy_a, 64'h0);
      step();
    end
    idle_a();
    read_a(5'd0, 5'd0);
    check_eq("x0_data_after", rd_data_a, 64'h0);
    check_eq("x0_busy_after", rd_busy_a, 64'h0);

    // Forwarding: reg5 = 0x11, then write 0x22 while reading it
    wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'h11;
    step();
    wr_data_a = 32'h22;
    read_a(5'd5, 5'd5);
    check_eq("fwd_n_p0", rd_data_a[31:0], FWD ? 64'h22 : 64'h11);
    check_eq("fwd_n_p1", rd_data_a[63:32], FWD ? 64'h22 : 64'h11);
    step();
    idle_a();
    read_a(5'd5, 5'd5);
    check_eq("fwd_n1_p0", rd_data_a[31:0], 64'h22);
    check_eq("fwd_n1_p1", rd_data_a[63:32], 64'h22);

    // Scoreboard life cycle on r7
    claim_en_a = 1'b1; claim_addr_a = 5'd7;
    read_a(5'd7, 5'd5);
    check_eq("sb_c0_busy", rd_busy_a, 64'h0);
    step();
    idle_a();
    read_a(5'd7, 5'd5);
    check_eq("sb_c1_busy", rd_busy_a, 64'h1);
    step();
    check_eq("sb_c2_busy", rd_busy_a, 64'h1);
    step();
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h1234;
    read_a(5'd7, 5'd5);
    check_eq("sb_c3_busy", rd_busy_a, FWD ? 64'h0 : 64'h1);
    check_eq("sb_c3_data", rd_data_a[31:0], FWD ? 64'h1234 : 64'h0);
    step();
    idle_a();
    read_a(5'd7, 5'd5);
    check_eq("sb_c4_busy", rd_busy_a, 64'h0);
    check_eq("sb_c4_data", rd_data_a[31:0], 64'h1234);

    // Claim/write collision on busy r9
    claim_en_a = 1'b1; claim_addr_a = 5'd9;
    step();
    wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'hAB;
    step();
    idle_a();
    read_a(5'd0, 5'd9);
    check_eq("coll_busy", rd_busy_a, 64'h2);
    check_eq("coll_data", rd_data_a[63:32], 64'hAB);

    // Write to a non-busy register: data updates, busy stays clear
    wr_en_a = 1'b1; wr_addr_a = 5'd12; wr_data_a = 32'hCAFE;
    step();
    idle_a();
    read_a(5'd12, 5'd9);
    check_eq("nb_data", rd_data_a[31:0], 64'hCAFE);
    check_eq("nb_busy", rd_busy_a, 64'h2);

    // Reset mid-operation with a claim pending
    rst = 1'b1;
    claim_en_a = 1'b1; claim_addr_a = 5'd9;
    step();
    rst = 1'b0;
    idle_a();
    read_a(5'd12, 5'd9);
    check_eq("mid_rst_data", rd_data_a, 64'h0);
    check_eq("mid_rst_busy", rd_busy_a, 64'h0);

    // Instance B: write 1..15 with pattern+i, then attempt a write to 0
    for (int i = 1; i < 16; i++) begin
      wr_en_b = 1'b1; wr_addr_b = 4'(i); wr_data_b = 64'h0123456789ABCDEF + 64'(i);
      step();
    end
    wr_en_b = 1'b1; wr_addr_b = 4'd0; wr_data_b = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    wr_en_b = 1'b0;
    rd_addr_b = {4'd12, 4'd7, 4'd3};
    #1;
    check_eq("b_p0_r3", rd_data_b[63:0], 64'h0123456789ABCDF2);
    check_eq("b_p1_r7", rd_data_b[127:64], 64'h0123456789ABCDF6);
    check_eq("b_p2_r12", rd_data_b[191:128], 64'h0123456789ABCDFB);
    check_eq("b_busy", rd_busy_b, 64'h0);
    rd_addr_b = {4'd15, 4'd0, 4'd1};
    #1;
    check_eq("b_p0_r1", rd_data_b[63:0], 64'h0123456789ABCDF0);
    check_eq("b_p1_r0", rd_data_b[127:64], 64'h0);
    check_eq("b_p2_r15", rd_data_b[191:128], 64'h0123456789ABCDFE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
